// File: rtl/ingress_header_router.sv
// ingress_header_router: packet-level AXIS demux placed after the ingress port manager.
// Validates the head-beat header carried in tuser and steers each whole packet to one
// of NUM_PORTS single-register output slots. Malformed or out-of-range packets are dropped.
// Optional statistics counters are enabled by defining INGRESS_ROUTER_STATS_EN; without it
// pkts_routed/pkts_dropped read as zero and routing is unchanged.

package ingress_header_router_pkg;

  typedef struct packed {
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [63:0] tuser;
    logic        tlast;
  } axis_m2s_t;

  typedef struct packed {
    logic tready;
  } axis_s2m_t;

endpackage

module ingress_header_router #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter logic [15:0] HDR_MAGIC     = 16'hABCD,
  parameter type         AXIS_M2S_TYPE = ingress_header_router_pkg::axis_m2s_t,
  parameter type         AXIS_S2M_TYPE = ingress_header_router_pkg::axis_s2m_t
) (
  input  logic         clk,
  input  logic         rst_n,
  input  AXIS_M2S_TYPE axis_in_m2s,
  output AXIS_S2M_TYPE axis_out_s2m,
  output AXIS_M2S_TYPE fab_out_m2s [NUM_PORTS],
  input  AXIS_S2M_TYPE fab_in_s2m  [NUM_PORTS],
  output logic [31:0]  pkts_routed,
  output logic [31:0]  pkts_dropped
);

  localparam int unsigned RW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RW-1:0]          r_route;
  AXIS_M2S_TYPE           r_slot [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_slot_free;
  logic                   w_head_valid;
  logic                   w_free_dst;
  logic                   w_free_route;
  logic                   w_tready;
  logic                   w_accept;
  logic                   w_load;
  logic [RW-1:0]          w_load_port;

  // Head-beat header check: magic must match and destination must exist.
  assign w_head_valid = (axis_in_m2s.tuser[31:16] == HDR_MAGIC) &&
                        (axis_in_m2s.tuser[15:8] < 8'(NUM_PORTS));

  // A slot can take a new beat when empty or being drained this cycle.
  always_comb begin
    w_slot_free = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_slot_free[i] = !r_slot[i].tvalid || fab_in_s2m[i].tready;
    end
  end

  // Select slot availability for the head's destination and for the latched route.
  always_comb begin
    w_free_dst   = 1'b0;
    w_free_route = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_free_dst   = (axis_in_m2s.tuser[15:8] == 8'(i)) ? w_slot_free[i] : w_free_dst;
      w_free_route = (r_route == RW'(i))               ? w_slot_free[i] : w_free_route;
    end
  end

  // Next-state and input-ready decode; body beats in FWD/DROP never look at tuser.
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (axis_in_m2s.tvalid) begin
          if (w_head_valid) begin
            w_tready = w_free_dst;
            if (w_free_dst && !axis_in_m2s.tlast) begin
              w_state_nxt = FWD;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tready = 1'b1;
            if (!axis_in_m2s.tlast) begin
              w_state_nxt = DROP;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end else begin
          w_tready = 1'b0;
        end
      end
      FWD: begin
        w_tready = w_free_route;
        if (axis_in_m2s.tvalid && w_free_route && axis_in_m2s.tlast) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FWD;
        end
      end
      DROP: begin
        w_tready = 1'b1;
        if (axis_in_m2s.tvalid && axis_in_m2s.tlast) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tready    = 1'b0;
      end
    endcase
  end

  assign w_accept    = axis_in_m2s.tvalid && w_tready;
  assign w_load      = w_accept && ((r_state == FWD) || ((r_state == IDLE) && w_head_valid));
  assign w_load_port = (r_state == IDLE) ? axis_in_m2s.tuser[8 +: RW] : r_route;

  // Drive the ready back to the port manager.
  always_comb begin
    axis_out_s2m        = '0;
    axis_out_s2m.tready = w_tready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the destination when a valid head is accepted; it steers the body beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_route <= '0;
    end else if ((r_state == IDLE) && w_head_valid && w_accept) begin
      r_route <= axis_in_m2s.tuser[8 +: RW];
    end
  end

  // Output slots: a new beat wins over a drain, otherwise a drained slot goes empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_load && (w_load_port == RW'(i))) begin
          r_slot[i] <= axis_in_m2s;
        end else if (fab_in_s2m[i].tready) begin
          r_slot[i].tvalid <= 1'b0;
        end
      end
    end
  end

  assign fab_out_m2s = r_slot;

`ifdef INGRESS_ROUTER_STATS_EN
  logic        w_pkt_end;
  logic        w_inc_routed;
  logic        w_inc_dropped;
  logic [31:0] r_pkts_routed;
  logic [31:0] r_pkts_dropped;

  // A packet ends on an accepted tlast; the state decides whether it was kept or dropped.
  assign w_pkt_end     = w_accept && axis_in_m2s.tlast;
  assign w_inc_routed  = w_pkt_end && ((r_state == FWD)  || ((r_state == IDLE) &&  w_head_valid));
  assign w_inc_dropped = w_pkt_end && ((r_state == DROP) || ((r_state == IDLE) && !w_head_valid));

  // Wrapping packet counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkts_routed  <= 32'h0;
      r_pkts_dropped <= 32'h0;
    end else begin
      if (w_inc_routed) begin
        r_pkts_routed <= r_pkts_routed + 32'h1;
      end
      if (w_inc_dropped) begin
        r_pkts_dropped <= r_pkts_dropped + 32'h1;
      end
    end
  end

  assign pkts_routed  = r_pkts_routed;
  assign pkts_dropped = r_pkts_dropped;
`else
  assign pkts_routed  = 32'h0;
  assign pkts_dropped = 32'h0;
`endif

endmodule
